text_cell_sequencer: RTL
========================

# text_cell_sequencer

Character-grid front end for the VGA text overlay. Holds a COLS×ROWS buffer of 6-bit glyph codes (0–9 digits, 10–35 letters, 36 space), written through a valid/ready port with an auto-advancing cursor. For each VGA pixel it looks up the owning cell and emits the glyph code, cell origin and delayed pixel coordinates. These outputs feed the fourteen-segment VGA drawer directly, with the drawer's height = GLYPH_H and width = GLYPH_W.

## Interface
Parameters:
- COLS, 16: characters per row.
- ROWS, 4: rows.
- TEXT_X0, 0: left edge of the grid in pixels.
- TEXT_Y0, 0: top edge of the grid in pixels.
- CELL_W, 40: cell pitch in x (pixels).
- CELL_H, 60: cell pitch in y (pixels).
- GLYPH_W, 32: glyph box width; must be ≤ CELL_W.
- GLYPH_H, 48: glyph box height; must be ≤ CELL_H.
- BLINK_FRAMES, 30: frame_tick pulses per cursor blink half-period.

Ports:
- clk  in  1  pixel clock; the block's only clock.
- reset  in  1  asynchronous, active-high reset.
- wr_valid  in  1  write request.
- wr_ready  out  1  block can accept a write.
- wr_char  in  6  glyph code, or control code 62 = clear, 63 = newline.
- pix_x  in  10  current pixel x coordinate.
- pix_y  in  10  current pixel y coordinate.
- frame_tick  in  1  one-cycle pulse per frame.
- out_x  out  10  pix_x delayed 2 cycles.
- out_y  out  10  pix_y delayed 2 cycles.
- character  out  6  glyph code for the pixel sampled 2 cycles earlier.
- x_start  out  10  cell glyph-box origin, x.
- y_start  out  10  cell glyph-box origin, y.
- cell_active  out  1  the sampled pixel lies inside a glyph box.
- cursor_col  out  $clog2(COLS)  current cursor column.
- cursor_row  out  $clog2(ROWS)  current cursor row.

## Operation
- Write-side FSM states: CLEAR, IDLE.
  - CLEAR: an address counter runs 0…COLS·ROWS−1 and writes 36 to each cell, one cell per cycle; wr_ready=0. On the last address, the cursor is set to (0,0) and the FSM moves to IDLE.
  - IDLE: wr_ready=1.
- A write is accepted on an edge where wr_valid && wr_ready.
  - Codes 0–36: stored at (cursor_col, cursor_row). The cursor then advances one column; past col COLS−1 it goes to col 0 of the next row; past row ROWS−1 it goes to row 0. There is no scrolling.
  - Codes 37–61: stored as 36 (space), with the same cursor advance.
  - Code 63 (newline): nothing is stored; col→0, row→(row+1) mod ROWS.
  - Code 62 (clear): the FSM enters CLEAR on the next cycle.
- Read pipeline (fully pipelined, one pixel per cycle):
  - Stage 1 computes dx = pix_x−TEXT_X0 and dy = pix_y−TEXT_Y0.
    - If pix_x < TEXT_X0 or pix_y < TEXT_Y0, the pixel is outside.
    - col = dx/CELL_W and row = dy/CELL_H, exact integer division.
    - The pixel is inside when col<COLS, row<ROWS, dx mod CELL_W < GLYPH_W and dy mod CELL_H < GLYPH_H.
    - x_start = TEXT_X0+col·CELL_W; y_start = TEXT_Y0+row·CELL_H.
  - Stage 2 performs a synchronous buffer read.
    - Outside pixels produce character=36 and cell_active=0.
    - x_start and y_start carry the computed values regardless of inside/outside.
- Buffer is a simple dual-port RAM, read-first. A same-cycle write and read of one cell returns the old code.

## Timing
- Reset (asynchronous) sets the following, and the FSM starts in CLEAR:
  - out_x=0, out_y=0, x_start=0, y_start=0.
  - character=36, cell_active=0.
  - cursor=(0,0), wr_ready=0.
- After reset deassert: exactly COLS·ROWS cycles of wr_ready=0, then wr_ready=1.
- Clear command accepted at edge N: wr_ready=0 from N+1 for COLS·ROWS cycles.
- Reset asserted mid-CLEAR: the clear restarts from address 0.
- Writes during CLEAR: not accepted; the source holds wr_valid.
- Latency pix → outputs = 2 cycles for all pixel-path outputs, which stay mutually aligned.
- Write accepted at edge N is visible to pixels sampled at cycle ≥ N+1.
- Cursor outputs update on the accepting edge.

## Configuration
- TEXT_CURSOR_BLINK_EN defined:
  - A frame counter counts frame_tick pulses and toggles a blink phase every BLINK_FRAMES ticks; the phase resets to on.
  - While the phase is on, the cell at the cursor outputs character=8 (all segments lit) instead of its stored code.
  - cell_active and x_start/y_start are unchanged.
- TEXT_CURSOR_BLINK_EN undefined:
  - No counter is built and frame_tick is ignored.
  - Stored codes are always output.

## Test plan
- Reset, deassert, count cycles → wr_ready low exactly 64 cycles (default 16×4). A sweep over all cells then reads character=36 everywhere.
- Write code 10 seventeen times → cursor=(1,1); cells (0..15,0) and (0,1) read 10.
- After wr_char=11 lands in cell (3,1), apply pix_x=125, pix_y=62 → 2 cycles later: character=11, x_start=120, y_start=60, cell_active=1, out_x=125. Apply pix_x=155 (dx mod 40 = 35 ≥ 32) → cell_active=0, character=36.
- Cursor at (5,3), send 63 → cursor=(0,0). Cursor at (15,3), write 7 → cursor=(0,0). Write code 50 → the cell reads 36.
- Send 62 with a full buffer; assert reset 10 cycles into the clear → wr_ready stays low 64 cycles after deassert, and all cells read 36.
- With TEXT_CURSOR_BLINK_EN and BLINK_FRAMES=2: cursor cell holding 36 reads character 8 for 2 frame_ticks, then 36 for 2 frame_ticks, repeating.

Source files
------------

// File: rtl/text_cell_sequencer.sv
// text_cell_sequencer: character-grid front end for the VGA text overlay.
// Holds a COLS x ROWS buffer of 6-bit glyph codes written via a valid/ready
// port with an auto-advancing cursor, and maps each pixel to its owning cell
// through a two-stage read pipeline feeding the fourteen-segment drawer.
// Optional feature macro: TEXT_CURSOR_BLINK_EN (blinking cursor cell).
module text_cell_sequencer #(
    parameter int COLS         = 16,
    parameter int ROWS         = 4,
    parameter int TEXT_X0      = 0,
    parameter int TEXT_Y0      = 0,
    parameter int CELL_W       = 40,
    parameter int CELL_H       = 60,
    parameter int GLYPH_W      = 32,
    parameter int GLYPH_H      = 48,
    parameter int BLINK_FRAMES = 30
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [5:0]               wr_char,
    input  logic [9:0]               pix_x,
    input  logic [9:0]               pix_y,
    input  logic                     frame_tick,
    output logic [9:0]               out_x,
    output logic [9:0]               out_y,
    output logic [5:0]               character,
    output logic [9:0]               x_start,
    output logic [9:0]               y_start,
    output logic                     cell_active,
    output logic [$clog2(COLS)-1:0]  cursor_col,
    output logic [$clog2(ROWS)-1:0]  cursor_row
);

    localparam int CELLS = COLS * ROWS;
    localparam int AW    = (CELLS > 1) ? $clog2(CELLS) : 1;
    localparam int CW    = $clog2(COLS);
    localparam int RW    = $clog2(ROWS);

    localparam logic [5:0] SPACE        = 6'd36;
    localparam logic [5:0] CODE_CLEAR   = 6'd62;
    localparam logic [5:0] CODE_NEWLINE = 6'd63;

    typedef enum logic {CLEAR, IDLE} state_t;

    state_t          state, state_n;
    logic [AW-1:0]   clr_addr, clr_addr_n;
    logic [CW-1:0]   col_n;
    logic [RW-1:0]   row_n;
    logic [RW-1:0]   row_inc;
    logic            mem_we;
    logic [AW-1:0]   mem_waddr;
    logic [5:0]      mem_wdata;
    logic [5:0]      mem [CELLS];
    logic [5:0]      rd_data;

    logic [10:0]     dx_ext, dy_ext;
    logic [9:0]      col_full, row_full, x_off, y_off;
    logic [9:0]      xs_c, ys_c;
    logic [AW-1:0]   addr_c;
    logic            inside_c;

    logic [9:0]      s1_x, s1_y, s1_xs, s1_ys;
    logic [AW-1:0]   s1_addr;
    logic            s1_inside;

    // Write-side next state: the clear sweep, then command decode and cursor advance while idle
    always_comb begin
        state_n    = state;
        clr_addr_n = clr_addr;
        col_n      = cursor_col;
        row_n      = cursor_row;
        wr_ready   = 1'b0;
        mem_we     = 1'b0;
        mem_waddr  = AW'(10'(cursor_row) * 10'(COLS) + 10'(cursor_col));
        mem_wdata  = (wr_char <= SPACE) ? wr_char : SPACE;
        row_inc    = (cursor_row == RW'(ROWS - 1)) ? '0 : cursor_row + RW'(1);
        case (state)
            CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = clr_addr;
                mem_wdata = SPACE;
                if (clr_addr == AW'(CELLS - 1)) begin
                    state_n    = IDLE;
                    clr_addr_n = '0;
                    col_n      = '0;
                    row_n      = '0;
                end else begin
                    clr_addr_n = clr_addr + AW'(1);
                end
            end
            IDLE: begin
                wr_ready = 1'b1;
                if (wr_valid) begin
                    if (wr_char == CODE_NEWLINE) begin
                        col_n = '0;
                        row_n = row_inc;
                    end else if (wr_char == CODE_CLEAR) begin
                        state_n    = CLEAR;
                        clr_addr_n = '0;
                    end else begin
                        mem_we = 1'b1;
                        if (cursor_col == CW'(COLS - 1)) begin
                            col_n = '0;
                            row_n = row_inc;
                        end else begin
                            col_n = cursor_col + CW'(1);
                        end
                    end
                end
            end
        endcase
    end

    // Write-side state, clear address and cursor registers; reset restarts the clear from address 0
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= CLEAR;
            clr_addr   <= '0;
            cursor_col <= '0;
            cursor_row <= '0;
        end else begin
            state      <= state_n;
            clr_addr   <= clr_addr_n;
            cursor_col <= col_n;
            cursor_row <= row_n;
        end
    end

    // Simple dual-port buffer, read-first: a same-edge write and read of one cell returns the old code
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
        rd_data <= mem[s1_addr];
    end

    // Stage 1 pixel-to-cell mapping; the extra top bit of dx/dy flags pixels left of or above the grid
    always_comb begin
        dx_ext   = {1'b0, pix_x} - 11'(TEXT_X0);
        dy_ext   = {1'b0, pix_y} - 11'(TEXT_Y0);
        col_full = dx_ext[9:0] / 10'(CELL_W);
        row_full = dy_ext[9:0] / 10'(CELL_H);
        x_off    = dx_ext[9:0] - col_full * 10'(CELL_W);
        y_off    = dy_ext[9:0] - row_full * 10'(CELL_H);
        inside_c = !dx_ext[10] && !dy_ext[10] &&
                   (col_full < 10'(COLS)) && (row_full < 10'(ROWS)) &&
                   (x_off < 10'(GLYPH_W)) && (y_off < 10'(GLYPH_H));
        xs_c     = 10'(TEXT_X0) + col_full * 10'(CELL_W);
        ys_c     = 10'(TEXT_Y0) + row_full * 10'(CELL_H);
        addr_c   = AW'(row_full * 10'(COLS) + col_full);
    end

    // Two pipeline stages keeping coordinates, cell origin and inside flag aligned with the buffer read
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_x        <= '0;
            s1_y        <= '0;
            s1_xs       <= '0;
            s1_ys       <= '0;
            s1_addr     <= '0;
            s1_inside   <= 1'b0;
            out_x       <= '0;
            out_y       <= '0;
            x_start     <= '0;
            y_start     <= '0;
            cell_active <= 1'b0;
        end else begin
            s1_x        <= pix_x;
            s1_y        <= pix_y;
            s1_xs       <= xs_c;
            s1_ys       <= ys_c;
            s1_addr     <= addr_c;
            s1_inside   <= inside_c;
            out_x       <= s1_x;
            out_y       <= s1_y;
            x_start     <= s1_xs;
            y_start     <= s1_ys;
            cell_active <= s1_inside;
        end
    end

`ifdef TEXT_CURSOR_BLINK_EN
    localparam int FW = $clog2(BLINK_FRAMES + 1);

    logic [FW-1:0] frame_cnt;
    logic          blink_on;
    logic          cursor_c, s1_cursor, s2_cursor;

    assign cursor_c = (col_full == 10'(cursor_col)) && (row_full == 10'(cursor_row));

    // Blink phase toggles every BLINK_FRAMES frame ticks and starts in the on phase
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (frame_tick) begin
            if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
                frame_cnt <= '0;
                blink_on  <= !blink_on;
            end else begin
                frame_cnt <= frame_cnt + FW'(1);
            end
        end
    end

    // Carry the cursor-cell flag alongside the read pipeline
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_cursor <= 1'b0;
            s2_cursor <= 1'b0;
        end else begin
            s1_cursor <= cursor_c;
            s2_cursor <= s1_cursor;
        end
    end

    assign character = !cell_active ? SPACE : ((s2_cursor && blink_on) ? 6'd8 : rd_data);
`else
    localparam int BLINK_FRAMES_UNUSED = BLINK_FRAMES;
    logic frame_tick_unused;

    assign frame_tick_unused = frame_tick;
    assign character         = cell_active ? rd_data : SPACE;
`endif

endmodule
